// File: rtl/mem_seq_pkg.sv
// Shared types and helpers for the memory address sequencer.
package mem_seq_pkg;

   // Access size encodings as seen on the size input.
   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   // Sequencer FSM states.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_e;

   // True when the low address bits suit the access size; the reserved size is never aligned.
   function automatic logic is_aligned(input logic [1:0] addr_lo, input logic [1:0] size);
      logic ok;
      ok = 1'b0;
      case (size)
         SZ_BYTE: ok = 1'b1;
         SZ_HALF: ok = (addr_lo[0] == 1'b0);
         SZ_WORD: ok = (addr_lo == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Combinational N:1 address mux over a flat source bus; out-of-range selects yield zero and oob.
module mux_n_sel #(
   parameter int NUM_SRC = 4,
   parameter int ADDR_W  = 32,
   localparam int SEL_W  = $clog2(NUM_SRC)
) (
   input  logic [SEL_W-1:0]          sel_i,
   input  logic [NUM_SRC*ADDR_W-1:0] src_i,
   output logic [ADDR_W-1:0]         addr_o,
   output logic                      oob_o
);

   // Pick the matching source slice; unmatched select values fall through to zero.
   always_comb begin
      addr_o = '0;
      oob_o  = (int'(sel_i) >= NUM_SRC);
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel_i == SEL_W'(i)) begin
            addr_o = src_i[i*ADDR_W +: ADDR_W];
         end
      end
   end

endmodule

// File: rtl/mem_addr_sequencer.sv
// Memory address sequencer: selects an address source, validates alignment, holds the
// registered address while issuing a valid/ready request, and aborts stalled accesses.
// Handshake: mem_valid stays high with mem_addr constant until a cycle with mem_ready
// high; that cycle completes the access, and mem_valid drops on the following edge.
module mem_addr_sequencer
   import mem_seq_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16,
   localparam int SEL_W  = $clog2(NUM_SRC)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [SEL_W-1:0]          sel,
   input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
   input  logic [1:0]                size,
   input  logic                      req,
   input  logic                      mem_ready,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_valid,
   output logic                      busy,
   output logic                      done,
   output logic                      err_addr,
   output logic                      err_timeout,
   output logic [SEL_W-1:0]          last_sel
);

   // Wait counter only needs to reach TIMEOUT-1; it saturates instead of wrapping.
   localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int TO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [SEL_W-1:0]   last_sel_q, last_sel_d;
   logic               done_q, done_d;
   logic               err_addr_q, err_addr_d;
   logic               err_to_q, err_to_d;

   logic [ADDR_W-1:0]  mux_addr;
   logic               mux_oob;

   mux_n_sel #(
      .NUM_SRC (NUM_SRC),
      .ADDR_W  (ADDR_W)
   ) u_mux (
      .sel_i  (sel),
      .src_i  (src_addr),
      .addr_o (mux_addr),
      .oob_o  (mux_oob)
   );

   // State, counter and output registers; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         last_sel_q <= '0;
         done_q     <= 1'b0;
         err_addr_q <= 1'b0;
         err_to_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         last_sel_q <= last_sel_d;
         done_q     <= done_d;
         err_addr_q <= err_addr_d;
         err_to_q   <= err_to_d;
      end
   end

   // Next-state logic: request acceptance in IDLE, completion or timeout in REQ.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      last_sel_d = last_sel_q;
      done_d     = 1'b0;
      err_addr_d = 1'b0;
      err_to_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               last_sel_d = sel;
               if (mux_oob || !is_aligned(mux_addr[1:0], size)) begin
                  err_addr_d = 1'b1;
               end else begin
                  addr_d  = mux_addr;
                  cnt_d   = '0;
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            // Completion takes priority over a timeout expiring in the same cycle.
            if (mem_ready) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LIM))) begin
               state_d  = ST_IDLE;
               err_to_d = 1'b1;
            end else if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Request strobes follow the state register directly so reset removes them at once.
   assign mem_valid   = (state_q == ST_REQ);
   assign busy        = (state_q != ST_IDLE);
   assign mem_addr    = addr_q;
   assign last_sel    = last_sel_q;
   assign done        = done_q;
   assign err_addr    = err_addr_q;
   assign err_timeout = err_to_q;

endmodule
